// File: rtl/switch_debouncer.sv
// Two-flop (or deeper) synchronizer plus a four-state debounce FSM that turns a bouncing
// board switch into a clean level X with single-cycle RISE/FALL pulses.
`timescale 1ns/1ps

module switch_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       RAW,
    output logic       X,
    output logic       RISE,
    output logic       FALL,
    output logic [1:0] State
);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        WAIT_HIGH   = 2'b01,
        STABLE_HIGH = 2'b10,
        WAIT_LOW    = 2'b11
    } state_e;

    localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] CNT_LAST = COUNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_e                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   rise_q, fall_q;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], RAW};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            STABLE_LOW: begin
                if (s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = STABLE_HIGH;
                        count_d = '0;
                    end else begin
                        state_d = WAIT_HIGH;
                        count_d = CNT_ONE;
                    end
                end else begin
                    count_d = '0;
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_d = STABLE_LOW;
                    count_d = '0;
                end else if (count_q == CNT_LAST) begin
                    state_d = STABLE_HIGH;
                    count_d = '0;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end
            STABLE_HIGH: begin
                if (!s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = STABLE_LOW;
                        count_d = '0;
                    end else begin
                        state_d = WAIT_LOW;
                        count_d = CNT_ONE;
                    end
                end else begin
                    count_d = '0;
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_d = STABLE_HIGH;
                    count_d = '0;
                end else if (count_q == CNT_LAST) begin
                    state_d = STABLE_LOW;
                    count_d = '0;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LOW;
                count_d = '0;
            end
        endcase
    end

    // Pulses key off the X bit itself, so a WAIT_LOW -> STABLE_HIGH bounce recovery emits nothing.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q <= STABLE_LOW;
            count_q <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rise_q  <= state_d[1] & ~state_q[1];
            fall_q  <= ~state_d[1] & state_q[1];
        end
    end

    assign X     = state_q[1];
    assign RISE  = rise_q;
    assign FALL  = fall_q;
    assign State = state_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer: a run-length model of the debounce rule is checked
// every cycle, and hand-computed latencies pin the model.
`timescale 1ns/1ps

module tb_switch_debouncer;

    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b0;
    logic       RAW   = 1'b0;
    logic       X, RISE, FALL;
    logic [1:0] State;

    always #5 CLOCK = ~CLOCK;

    switch_debouncer #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .COUNT_WIDTH    (16)
    ) dut (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .RAW  (RAW),
        .X    (X),
        .RISE (RISE),
        .FALL (FALL),
        .State(State)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: X follows the synchronized input once it has differed from X for DEB edges in a row.
    bit   raw_hist [0:4095];
    int   n_edges = 0;
    int   m_run   = 0;
    logic m_x     = 1'b0;
    logic m_rise  = 1'b0;
    logic m_fall  = 1'b0;
    logic m_s, m_prev;

    initial forever begin
        @(posedge CLOCK or negedge RESET);
        if (!RESET) begin
            n_edges = 0;
            m_run   = 0;
            m_x     = 1'b0;
            m_rise  = 1'b0;
            m_fall  = 1'b0;
        end else begin
            m_s = (n_edges >= SYNC) ? raw_hist[(n_edges - SYNC) % 4096] : 1'b0;
            raw_hist[n_edges % 4096] = RAW;
            n_edges++;
            m_prev = m_x;
            if (m_s != m_x) m_run++;
            else m_run = 0;
            if (m_run == DEB) begin
                m_x   = m_s;
                m_run = 0;
            end
            m_rise = m_x & ~m_prev;
            m_fall = ~m_x & m_prev;
        end
    end

    logic       x_prev     = 1'b0;
    bit         prev_valid = 1'b0;
    logic [1:0] m_state;

    initial forever begin
        @(negedge CLOCK);
        m_state = {m_x, (m_run != 0)};
        check("x",     X,     m_x);
        check("rise",  RISE,  m_rise);
        check("fall",  FALL,  m_fall);
        check("state", State, m_state);
        if (RESET) begin
            // The downstream Moore machine sees X change only alongside a pulse.
            if (prev_valid) check("x_change_iff_pulse", (X !== x_prev), (RISE | FALL));
            x_prev     = X;
            prev_valid = 1'b1;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic do_reset();
        @(negedge CLOCK);
        #1 RESET = 1'b0;
        repeat (2) @(negedge CLOCK);
        #1;
    endtask

    int rises, falls, rise_at, fall_at;
    bit saw_wait;
    bit bounce [0:4];

    initial begin
        // Reset with RAW low, then ten idle cycles.
        RESET = 1'b0;
        RAW   = 1'b0;
        repeat (2) @(negedge CLOCK);
        #1;
        check("rst_x", X, 0);
        check("rst_rise", RISE, 0);
        check("rst_fall", FALL, 0);
        check("rst_state", State, 0);
        RESET = 1'b1;
        repeat (10) @(posedge CLOCK);
        #1;
        check("idle_x", X, 0);
        check("idle_state", State, 0);

        // Clean rise: RAW high before edge 0.
        do_reset();
        RAW   = 1'b1;
        RESET = 1'b1;
        rises = 0; rise_at = -1;
        for (int e = 0; e < 8; e++) begin
            @(posedge CLOCK);
            #1;
            if (RISE) begin rises++; rise_at = e; end
            if (e == 1) check("rise_state_e1", State, 2'b00);
            if (e == 2) check("rise_state_e2", State, 2'b01);
            if (e == 4) check("rise_x_e4", X, 0);
            if (e == 5) begin
                check("rise_x_e5", X, 1);
                check("rise_state_e5", State, 2'b10);
            end
        end
        check("rise_count", rises, 1);
        check("rise_edge", rise_at, 5);

        // Clean fall from STABLE_HIGH.
        RAW   = 1'b0;
        falls = 0; fall_at = -1;
        for (int e = 0; e < 8; e++) begin
            @(posedge CLOCK);
            #1;
            if (FALL) begin falls++; fall_at = e; end
            if (e == 2) check("fall_state_e2", State, 2'b11);
            if (e == 4) check("fall_x_e4", X, 1);
        end
        check("fall_count", falls, 1);
        check("fall_edge", fall_at, 5);
        check("fall_state_end", State, 2'b00);

        // Three-edge excursion is rejected.
        rises = 0; saw_wait = 1'b0;
        for (int e = 0; e < 12; e++) begin
            RAW = (e < 3);
            @(posedge CLOCK);
            #1;
            if (RISE) rises++;
            if (State == 2'b01) saw_wait = 1'b1;
        end
        check("short_rises", rises, 0);
        check("short_saw_wait", saw_wait, 1);
        check("short_x", X, 0);
        check("short_state", State, 2'b00);

        // Bounce 1,0,1,1,0 then held high: S settles at edge 6, X rises after edge 10.
        bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        rises = 0; falls = 0; rise_at = -1;
        for (int e = 0; e < 16; e++) begin
            RAW = (e < 5) ? bounce[e] : 1'b1;
            @(posedge CLOCK);
            #1;
            if (RISE) begin rises++; rise_at = e; end
            if (FALL) falls++;
        end
        check("bounce_rises", rises, 1);
        check("bounce_falls", falls, 0);
        check("bounce_edge", rise_at, 10);

        // Reset in the middle of WAIT_HIGH, released with RAW still high.
        do_reset();
        RAW   = 1'b0;
        RESET = 1'b1;
        repeat (4) @(posedge CLOCK);
        #1 RAW = 1'b1;
        repeat (3) @(posedge CLOCK);
        #1;
        check("mid_state_wait", State, 2'b01);
        #1 RESET = 1'b0;
        #1;
        check("mid_rst_x", X, 0);
        check("mid_rst_state", State, 0);
        check("mid_rst_pulses", {RISE, FALL}, 0);
        @(negedge CLOCK);
        #1 RESET = 1'b1;
        rises = 0; rise_at = -1;
        for (int e = 0; e < 8; e++) begin
            @(posedge CLOCK);
            #1;
            if (RISE) begin rises++; rise_at = e; end
        end
        check("release_rises", rises, 1);
        check("release_edge", rise_at, 5);

        // Reset while RISE is high aborts the pulse.
        do_reset();
        RAW   = 1'b1;
        RESET = 1'b1;
        repeat (6) @(posedge CLOCK);
        #1;
        check("abort_rise_before", RISE, 1);
        RESET = 1'b0;
        #1;
        check("abort_rise_after", RISE, 0);
        check("abort_x_after", X, 0);
        check("abort_state_after", State, 0);
        @(negedge CLOCK);
        #1;
        RAW   = 1'b0;
        RESET = 1'b1;
        rises = 0; falls = 0;
        for (int e = 0; e < 8; e++) begin
            @(posedge CLOCK);
            #1;
            if (RISE) rises++;
            if (FALL) falls++;
        end
        check("abort_no_pulses", rises + falls, 0);
        check("abort_x_end", X, 0);

        @(negedge CLOCK);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
